// File: rtl/md5_msg_packer.sv
// rtl/md5_msg_packer.sv - packs keyboard ASCII into one padded MD5 block, streamed as 16 LE words
// Optional echo outputs enabled by defining MD5_MSG_ECHO_EN.
module md5_msg_packer #(
    parameter int          MAX_LEN    = 55,
    parameter logic [7:0]  BS_CODE    = 8'h08,
    parameter logic [7:0]  ENTER_CODE = 8'h0D
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  key_data,
    input  logic        key_en,
    output logic [31:0] blk_word,
    output logic [3:0]  blk_idx,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        blk_last,
    output logic [5:0]  msg_len,
    output logic        busy,
    output logic        overflow
`ifdef MD5_MSG_ECHO_EN
    ,
    output logic [7:0]  echo_data,
    output logic        echo_valid
`endif
);

    typedef enum logic [1:0] {COLLECT, PAD, EMIT} state_t;

    state_t      state, state_nxt;
    logic        key_prev;
    logic [5:0]  pad_ptr;
    logic [7:0]  pad_byte;
    logic [7:0]  buf_mem [0:63];

    logic strobe, printable, is_enter, is_bs;
    logic do_store, do_drop, do_bs, do_enter, hs;

    assign strobe    = key_en && !key_prev;
    assign printable = (key_data >= 8'h20) && (key_data <= 8'h7E);
    assign is_enter  = (key_data == ENTER_CODE);
    assign is_bs     = (key_data == BS_CODE);

    // Enter and backspace take priority over the printable test.
    assign do_enter = (state == COLLECT) && strobe && is_enter;
    assign do_bs    = (state == COLLECT) && strobe && !is_enter && is_bs && (msg_len != 6'd0);
    assign do_store = (state == COLLECT) && strobe && !is_enter && !is_bs && printable
                      && (msg_len < 6'(MAX_LEN));
    assign do_drop  = (state == COLLECT) && strobe && !is_enter && !is_bs && printable
                      && (msg_len >= 6'(MAX_LEN));
    assign hs       = blk_valid && blk_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (do_enter) state_nxt = PAD;
            PAD:     if (pad_ptr == 6'd63) state_nxt = EMIT;
            EMIT:    if (hs && (blk_idx == 4'd15)) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= COLLECT;
        else     state <= state_nxt;
    end

    // 0x80 terminator, zero fill, then the 64-bit bit length (msg_len*8 fits in 9 bits).
    always_comb begin
        pad_byte = 8'h00;
        if (pad_ptr == msg_len)     pad_byte = 8'h80;
        else if (pad_ptr == 6'd56)  pad_byte = {msg_len[4:0], 3'b000};
        else if (pad_ptr == 6'd57)  pad_byte = {7'b0, msg_len[5]};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            key_prev  <= key_en;
            msg_len   <= 6'd0;
            overflow  <= 1'b0;
            blk_valid <= 1'b0;
            blk_idx   <= 4'd0;
            pad_ptr   <= 6'd0;
        end else begin
            key_prev <= key_en;
            if (do_store) msg_len  <= msg_len + 6'd1;
            if (do_bs)    msg_len  <= msg_len - 6'd1;
            if (do_drop)  overflow <= 1'b1;
            if (do_enter) pad_ptr  <= msg_len;
            if (state == PAD) begin
                pad_ptr <= pad_ptr + 6'd1;
                if (pad_ptr == 6'd63) begin
                    blk_valid <= 1'b1;
                    blk_idx   <= 4'd0;
                end
            end
            if ((state == EMIT) && hs) begin
                if (blk_idx == 4'd15) begin
                    blk_valid <= 1'b0;
                    blk_idx   <= 4'd0;
                    msg_len   <= 6'd0;
                    overflow  <= 1'b0;
                end else begin
                    blk_idx <= blk_idx + 4'd1;
                end
            end
        end
    end

    // Message storage is not reset; every byte read out is rewritten by COLLECT or PAD first.
    always_ff @(posedge clk) begin
        if (do_store)
            buf_mem[msg_len] <= key_data;
        else if (state == PAD)
            buf_mem[pad_ptr] <= pad_byte;
    end

`ifdef MD5_MSG_ECHO_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            echo_valid <= 1'b0;
            echo_data  <= 8'h00;
        end else begin
            echo_valid <= do_store || do_bs || do_enter;
            if (do_store || do_bs || do_enter)
                echo_data <= do_bs ? BS_CODE : key_data;
        end
    end
`endif

    assign blk_word = blk_valid ? {buf_mem[{blk_idx, 2'd3}], buf_mem[{blk_idx, 2'd2}],
                                   buf_mem[{blk_idx, 2'd1}], buf_mem[{blk_idx, 2'd0}]} : 32'd0;
    assign blk_last = blk_valid && (blk_idx == 4'd15);
    assign busy     = (state != COLLECT);

endmodule

// File: tb/tb_md5_msg_packer.sv
// tb/tb_md5_msg_packer.sv - scoreboard bench for md5_msg_packer with a byte-level MD5 padding model
module tb_md5_msg_packer;

    logic        clk = 1'b0;
    logic        clr, key_en, blk_ready;
    logic [7:0]  key_data;
    logic [31:0] blk_word;
    logic [3:0]  blk_idx;
    logic        blk_valid, blk_last, busy, overflow;
    logic [5:0]  msg_len;
`ifdef MD5_MSG_ECHO_EN
    logic [7:0]  echo_data;
    logic        echo_valid;
    logic [7:0]  echo_q[$];
    bit          echo_prev = 0;
`endif

    always #5 clk = ~clk;

    md5_msg_packer dut (
        .clk(clk), .clr(clr), .key_data(key_data), .key_en(key_en),
        .blk_word(blk_word), .blk_idx(blk_idx), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_last(blk_last), .msg_len(msg_len), .busy(busy), .overflow(overflow)
`ifdef MD5_MSG_ECHO_EN
        , .echo_data(echo_data), .echo_valid(echo_valid)
`endif
    );

    typedef struct {
        logic [31:0] w;
        logic [3:0]  idx;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    exp_t        exp_q[$];
    logic [7:0]  msg[$];
    bit          m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: build the padded 64-byte block from the stored message, then slice into LE words.
    task automatic push_block();
        logic [7:0]  m [64];
        logic [15:0] bits;
        int          len;
        exp_t        e;
        len = msg.size();
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        for (int i = 0; i < len; i++) m[i] = msg[i];
        m[len] = 8'h80;
        bits = 16'(len * 8);
        m[56] = bits[7:0];
        m[57] = bits[15:8];
        for (int w = 0; w < 16; w++) begin
            e.w   = {m[4*w+3], m[4*w+2], m[4*w+1], m[4*w]};
            e.idx = 4'(w);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_key(input logic [7:0] code);
        if (code == 8'h08) begin
            if (msg.size() > 0) begin
                void'(msg.pop_back());
`ifdef MD5_MSG_ECHO_EN
                echo_q.push_back(8'h08);
`endif
            end
        end else if (code >= 8'h20 && code <= 8'h7E) begin
            if (msg.size() < 55) begin
                msg.push_back(code);
`ifdef MD5_MSG_ECHO_EN
                echo_q.push_back(code);
`endif
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic press(input logic [7:0] code, input int hold);
        key_data = code;
        key_en   = 1'b1;
        model_key(code);
        cyc(hold);
        key_en = 1'b0;
        cyc(2);
        chk("msg_len", 32'(msg_len), 32'(msg.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy_collect", 32'(busy), 32'd0);
    endtask

    task automatic enter(input int rmode, input bit bp, input bit hold_long);
        int len, cnt, n;
        bit bp_done;
        len = msg.size();
        push_block();
`ifdef MD5_MSG_ECHO_EN
        echo_q.push_back(8'h0D);
`endif
        hs_count  = 0;
        blk_ready = 1'b0;
        key_data  = 8'h0D;
        key_en    = 1'b1;
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (!blk_valid && cnt < 200);
        chk("valid_latency", 32'(cnt), 32'(65 - len));
        if (!hold_long) key_en = 1'b0;
        n = 0;
        bp_done = 0;
        while (hs_count < 16 && n < 2000) begin
            if (bp && !bp_done && blk_valid && blk_idx == 4'd5) begin
                bp_done   = 1;
                blk_ready = 1'b0;
                key_data  = 8'h7A;
                key_en    = 1'b0;
                cyc(1);
                key_en = 1'b1;
                cyc(3);
                key_en = 1'b0;
                cyc(6);
                chk("bp_idx", 32'(blk_idx), 32'd5);
                chk("bp_valid", 32'(blk_valid), 32'd1);
            end
            blk_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cyc(1);
            n++;
        end
        chk("emit_handshakes", 32'(hs_count), 32'd16);
        blk_ready = 1'b0;
        msg.delete();
        m_ovf = 0;
        cyc(2);
        key_en = 1'b0;
        cyc(2);
        chk("post_msg_len", 32'(msg_len), 32'd0);
        chk("post_overflow", 32'(overflow), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_valid", 32'(blk_valid), 32'd0);
    endtask

    task automatic reset_mid_emit();
        int cnt;
        push_block();
`ifdef MD5_MSG_ECHO_EN
        echo_q.push_back(8'h0D);
`endif
        blk_ready = 1'b0;
        key_data  = 8'h0D;
        key_en    = 1'b1;
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (!blk_valid && cnt < 200);
        key_en = 1'b0;
        chk("rst_valid_rise", 32'(blk_valid), 32'd1);
        blk_ready = 1'b1;
        cyc(4);
        blk_ready = 1'b0;
        cyc(1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("rst_valid", 32'(blk_valid), 32'd0);
        chk("rst_msg_len", 32'(msg_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(blk_idx), 32'd0);
        exp_q.delete();
        msg.delete();
        m_ovf = 0;
        cyc(2);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stability while stalled.
    logic [31:0] prev_w;
    logic [3:0]  prev_i;
    bit          prev_stall = 0;
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(blk_valid), 32'd1);
                chk("stall_word", blk_word, prev_w);
                chk("stall_idx", 32'(blk_idx), 32'(prev_i));
            end
            if (!blk_valid) chk("last_idle", 32'(blk_last), 32'd0);
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got idx %0d word %h, scoreboard empty", blk_idx, blk_word);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", blk_word, e.w);
                    chk("idx", 32'(blk_idx), 32'(e.idx));
                    chk("last", 32'(blk_last), 32'(e.idx == 4'd15));
                end
                hs_count++;
            end
            prev_stall = blk_valid && !blk_ready;
            prev_w     = blk_word;
            prev_i     = blk_idx;
        end
    end

`ifdef MD5_MSG_ECHO_EN
    always @(negedge clk) begin
        if (!clr && echo_valid) begin
            if (echo_prev) begin
                checks++;
                errors++;
                $display("FAIL echo_width: echo_valid high on consecutive cycles");
            end
            if (echo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL echo_unexpected: got %h, none expected", echo_data);
            end else begin
                chk("echo_data", 32'(echo_data), 32'(echo_q.pop_front()));
            end
        end
        echo_prev = echo_valid;
    end
`endif

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] code;
        int r;
        clr = 1'b1;
        key_en = 1'b1;
        key_data = 8'h71;
        blk_ready = 1'b0;
        cyc(3);
        clr = 1'b0;
        cyc(3);
        chk("reset_valid", 32'(blk_valid), 32'd0);
        chk("reset_idx", 32'(blk_idx), 32'd0);
        chk("reset_word", blk_word, 32'd0);
        chk("reset_last", 32'(blk_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_held_key", 32'(msg_len), 32'd0);
        key_en = 1'b0;
        cyc(2);

        press(8'h61, 200);
        press(8'h62, 200);
        press(8'h63, 200);
        enter(0, 0, 0);

        press(8'h61, 3);
        press(8'h08, 3);
        press(8'h08, 3);
        enter(0, 0, 0);

        press(8'h61, 2);
        press(8'h62, 2);
        press(8'h08, 2);
        press(8'h63, 2);
        enter(1, 0, 1);

        for (int i = 0; i < 56; i++) press(8'h78, 2);
        enter(0, 1, 0);

        press(8'h41, 2);
        press(8'h42, 2);
        reset_mid_emit();

        for (int s = 0; s < 20; s++) begin
            r = $urandom_range(0, 62);
            for (int k = 0; k < r; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: code = 8'($urandom_range(32, 126));
                    6, 7:             code = 8'h08;
                    default: begin
                        do code = 8'($urandom_range(0, 255));
                        while ((code >= 8'h20 && code <= 8'h7E) || code == 8'h08 || code == 8'h0D);
                    end
                endcase
                press(code, $urandom_range(1, 12));
            end
            enter(1, (s % 5) == 0, (s % 3) == 0);
        end

        cyc(5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef MD5_MSG_ECHO_EN
        chk("echo_empty", 32'(echo_q.size()), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md5_msg_packer.md
Name: md5_msg_packer

Overview:
- Sits directly downstream of the PS/2 keyboard front end (kbd), consuming its `outdata`/`en` ASCII stream.
- Assembles typed characters into a single 512-bit MD5 message block, applying standard MD5 padding and the 64-bit length field.
- Streams the block as 16 little-endian 32-bit words to the MD5 core over a valid/ready handshake.
- Supports Backspace editing and Enter to commit.

Parameters:
- MAX_LEN, 55, maximum stored characters; must be ≤55 so the block fits in one MD5 block.
- BS_CODE, 8'h08, ASCII code treated as backspace.
- ENTER_CODE, 8'h0D, ASCII code that commits the message.

Ports:
- clk  in  1  system clock; the single clock domain.
- clr  in  1  synchronous reset, active-high.
- key_data  in  8  ASCII code from the keyboard stage.
- key_en  in  1  key-valid level from the keyboard stage; may stay high for many clk cycles.
- blk_word  out  32  current message word: {byte[4i+3], byte[4i+2], byte[4i+1], byte[4i]}.
- blk_idx  out  4  index i of blk_word, 0..15.
- blk_valid  out  1  blk_word/blk_idx are valid.
- blk_ready  in  1  MD5 core accepts the word on a cycle where blk_valid && blk_ready.
- blk_last  out  1  high together with blk_valid when blk_idx==15.
- msg_len  out  6  number of characters currently stored.
- busy  out  1  high in PAD and EMIT states.
- overflow  out  1  sticky: a printable character was dropped because msg_len==MAX_LEN.

Behaviour:
- Reset (clr=1 at a clk edge):
  - state=COLLECT; msg_len=0; blk_valid=0; blk_last=0; blk_idx=0; blk_word=0; busy=0; overflow=0.
  - Edge-detect register is loaded with the current key_en value, so a key held through reset is not captured.
  - Buffer contents need not be cleared.
  - Reset overrides every state, including mid-PAD and mid-EMIT.
- Key strobe:
  - key_en is sampled every clk; a strobe is a cycle where key_en=1 and the previous sample was 0.
  - Exactly one action is taken per strobe, regardless of how long key_en stays high.
- COLLECT, on a strobe:
  - key_data==ENTER_CODE → go to PAD, with pad pointer = msg_len.
  - key_data==BS_CODE → msg_len-1 if msg_len>0; no change if msg_len==0.
  - Printable key_data (0x20..0x7E) with msg_len<MAX_LEN → buf[msg_len]=key_data, msg_len+1.
  - Printable key_data with msg_len==MAX_LEN → discarded; overflow=1.
  - Any other code → ignored.
- PAD:
  - Writes one byte per clk at the pad pointer, then increments the pointer.
  - Byte values: pointer==msg_len → 0x80; msg_len<pointer<56 → 0x00; 56..63 → bytes of the 64-bit bit length L=msg_len*8, little-endian (byte 56 = L[7:0], byte 57 = L[15:8], bytes 58..63 = 0).
  - Leaves PAD after writing byte 63, i.e. PAD lasts exactly 64-msg_len cycles.
  - Next state is EMIT with blk_idx=0 and blk_valid=1.
  - blk_valid therefore first rises 65-msg_len cycles after the Enter strobe cycle.
- EMIT:
  - blk_word, blk_idx and blk_last are held stable while blk_valid && !blk_ready.
  - On a handshake with blk_idx<15 → blk_idx+1, word updated on the next cycle, blk_valid stays 1.
  - On a handshake with blk_idx==15 → blk_valid=0, blk_idx=0, msg_len=0, overflow=0, state=COLLECT.
  - blk_valid never drops before its handshake completes.
- Strobes during PAD/EMIT are ignored, but edge detection keeps tracking key_en. A key still held when the state returns to COLLECT does not fire.
- busy=1 iff state is PAD or EMIT.
- Backspace and overflow interaction: Backspace after an overflow does not clear overflow; only an emit completion or reset clears it.

Optional Feature:
- Macro: MD5_MSG_ECHO_EN.
- When defined, two extra outputs exist: echo_data (8 bits) and echo_valid (1 bit), for a display/terminal stage.
- echo_valid pulses high for exactly 1 clk, the cycle after each accepted action:
  - stored character → echo_data = that character;
  - effective backspace (msg_len was >0) → echo_data = BS_CODE;
  - Enter → echo_data = ENTER_CODE.
- No echo is produced for discarded or ignored keys.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Type "abc" (0x61, 0x62, 0x63), each key_en held 200 cycles, then Enter, with blk_ready=1 → words: idx0=0x80636261, idx1..13=0, idx14=0x00000018, idx15=0. blk_valid first rises 62 cycles after the Enter strobe; blk_last only on idx15; msg_len returns to 0.
- Enter with an empty buffer → idx0=0x00000080, all other words 0. Also check: BS at msg_len=0 keeps msg_len=0.
- "a", "b", BS, "c", Enter → idx0=0x80636361? No: the stored message is "ac", so idx0=0x00806361 and idx14=0x00000010.
- Type 56 × 'x' (0x78) → msg_len=55 with overflow=1 after the 56th key. Enter → idx13=0x80787878, idx14=0x000001B8. overflow clears after idx15 is accepted.
- Backpressure and reset:
  - Hold blk_ready=0 for 10 cycles while blk_idx==5 → blk_word/blk_idx/blk_valid remain stable, and keys strobed during that time are ignored.
  - Assert clr mid-EMIT → blk_valid=0, msg_len=0, state COLLECT on the next cycle.
- With MD5_MSG_ECHO_EN defined: "a", BS, BS, Enter → echo pulses 0x61, 0x08, 0x0D (the second BS is not echoed), each exactly 1 cycle wide.
